nios2_subsystem_pio_fifo_buf: RTL and testbench

//   Buffered Avalon-MM input PIO for the Nios II subsystem. Captures a streaming sample bus into
//   a DEPTH-entry FIFO; the CPU pops samples through a DATA register and reads level and error

---
 rtl/nios2_subsystem_pio_fifo_buf.sv | 160 ++++++++++++++++
 tb/tb_nios2_subsystem_pio_fifo_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_subsystem_pio_fifo_buf.sv
// Buffered Avalon-MM input PIO: streaming samples land in a FIFO that the CPU drains through DATA.
// Define PIO_FIFO_BUF_IRQ_EN to build the level-threshold interrupt, CONTROL.irq_en and THRESH.
module nios2_subsystem_pio_fifo_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [LVL_W-1:0]  r_level;
    logic [31:0]       r_readdata;
    logic              r_ovf;
    logic              r_udf;

    logic              w_empty;
    logic              w_full;
    logic              w_popReq;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_underflow;
    logic              w_flush;
    logic              w_clrOvf;
    logic              w_clrUdf;
    logic              w_irqEnRd;
    logic [LVL_W-1:0]  w_threshRd;
    logic              w_irq;
    logic [31:0]       w_headExt;
    logic [31:0]       w_status;
    logic [31:0]       w_readNext;
    logic              w_unused;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == FULL_LVL);
    assign in_ready    = !w_full;
    assign w_popReq    = chipselect && read && (address == 2'd0);
    assign w_pop       = w_popReq && !w_empty;
    assign w_underflow = w_popReq && w_empty;
    assign w_flush     = chipselect && write && (address == 2'd2) && writedata[1];
    // A full FIFO still accepts a sample when a pop frees the head on the same edge.
    assign w_push      = in_valid && (!w_full || w_pop) && !w_flush;
    assign w_drop      = in_valid && w_full && !w_pop;
    assign w_clrOvf    = chipselect && write && (address == 2'd1) && writedata[2];
    assign w_clrUdf    = chipselect && write && (address == 2'd1) && writedata[3];
    assign w_unused    = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags: a new event on the same edge beats a software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_drop)          r_ovf <= 1'b1;
            else if (w_clrOvf)   r_ovf <= 1'b0;
            if (w_underflow)     r_udf <= 1'b1;
            else if (w_clrUdf)   r_udf <= 1'b0;
        end
    end

`ifdef PIO_FIFO_BUF_IRQ_EN
    logic             r_irqEn;
    logic [LVL_W-1:0] r_thresh;
    logic             r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqEn  <= 1'b0;
            r_thresh <= LVL_W'(1);
            r_irq    <= 1'b0;
        end else begin
            if (chipselect && write && (address == 2'd2)) r_irqEn <= writedata[0];
            if (chipselect && write && (address == 2'd3))
                r_thresh <= (writedata[LVL_W-1:0] == '0) ? LVL_W'(1) : writedata[LVL_W-1:0];
            r_irq <= r_irqEn && ((r_level >= r_thresh) || r_ovf);
        end
    end

    assign w_irqEnRd  = r_irqEn;
    assign w_threshRd = r_thresh;
    assign w_irq      = r_irq;
`else
    assign w_irqEnRd  = 1'b0;
    assign w_threshRd = '0;
    assign w_irq      = 1'b0;
`endif

    always_comb begin
        w_headExt = '0;
        w_headExt[DATA_W-1:0] = r_mem[r_rdPtr];
        w_status = '0;
        w_status[0] = w_empty;
        w_status[1] = w_full;
        w_status[2] = r_ovf;
        w_status[3] = r_udf;
        w_status[4] = w_irq;
        w_status[16 +: LVL_W] = r_level;
        case (address)
            2'd0:    w_readNext = w_empty ? 32'd0 : w_headExt;
            2'd1:    w_readNext = w_status;
            2'd2:    w_readNext = {31'd0, w_irqEnRd};
            default: w_readNext = {{(32-LVL_W){1'b0}}, w_threshRd};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (chipselect && read) begin
            r_readdata <= w_readNext;
        end
    end

    assign readdata = r_readdata;
    assign irq      = w_irq;

endmodule

// File: tb/tb_nios2_subsystem_pio_fifo_buf.sv
// Self-checking bench for nios2_subsystem_pio_fifo_buf: a FIFO model feeds a queue of expected reads.
module tb_nios2_subsystem_pio_fifo_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    int          checksTotal  = 0;
    int          checksPassed = 0;
    logic [31:0] expQ[$];
    logic [31:0] model[$];

    nios2_subsystem_pio_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    endtask

    // One clock of bus/stream activity; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic cs,
                                 input logic rd, input logic wr, input logic [1:0] addr,
                                 input logic [31:0] wdata);
        in_valid   = valid;
        in_data    = data[DATA_W-1:0];
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wdata;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = 32'd0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic pushSample(input logic [31:0] d);
        if (model.size() < DEPTH) model.push_back(d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] d);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, addr, d);
    endtask

    task automatic readReg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        expQ.push_back(exp);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, addr, 32'd0);
        checkOutput(tag, readdata, expQ.pop_front());
    endtask

    task automatic popData(input string tag);
        logic [31:0] exp;
        exp = (model.size() > 0) ? model.pop_front() : 32'd0;
        readReg(tag, 2'd0, exp);
    endtask

    // Pop and push on the same edge; on an empty FIFO the pop underflows but the sample is kept.
    task automatic pushPop(input string tag, input logic [31:0] d);
        if (model.size() > 0) expQ.push_back(model.pop_front());
        else expQ.push_back(32'd0);
        model.push_back(d);
        applyStimulus(1'b1, d, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        checkOutput(tag, readdata, expQ.pop_front());
    endtask

    function automatic logic [31:0] statusWord(input bit e, input bit f, input bit o, input bit u,
                                               input bit i, input int lvl);
        logic [31:0] s;
        s = '0;
        s[0] = e;
        s[1] = f;
        s[2] = o;
        s[3] = u;
        s[4] = i;
        s[31:16] = lvl[15:0];
        return s;
    endfunction

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_readdata", readdata, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        idleCycle();
        checkOutput("post_rst_readdata", readdata, 32'd0);
        readReg("post_rst_status", 2'd1, 32'h0000_0001);

        pushSample(32'hA5);
        pushSample(32'h5A);
        readReg("two_status", 2'd1, statusWord(0, 0, 0, 0, 0, 2));
        popData("pop_a5");
        popData("pop_5a");
        idleCycle();
        checkOutput("readdata_hold", readdata, 32'h5A);
        readReg("drained_status", 2'd1, 32'h0000_0001);

        for (int i = 0; i < DEPTH; i++) pushSample(32'h100 + i);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        readReg("full_no_ovf", 2'd1, statusWord(0, 1, 0, 0, 0, DEPTH));
        pushSample(32'h1FF);
        readReg("ovf_status", 2'd1, statusWord(0, 1, 1, 0, 0, DEPTH));
        popData("first_after_ovf");
        pushSample(32'h200);
        writeReg(2'd1, 32'h4);
        readReg("ovf_cleared", 2'd1, statusWord(0, 1, 0, 0, 0, DEPTH));
        pushPop("full_pushpop", 32'h300);
        readReg("full_pushpop_status", 2'd1, statusWord(0, 1, 0, 0, 0, DEPTH));
        writeReg(2'd0, 32'hFFFF_FFFF);
        readReg("data_write_ignored", 2'd1, statusWord(0, 1, 0, 0, 0, DEPTH));
        for (int i = 0; i < DEPTH; i++) popData($sformatf("drain_%0d", i));
        readReg("drain_status", 2'd1, 32'h0000_0001);

        popData("pop_empty");
        readReg("udf_status", 2'd1, statusWord(1, 0, 0, 1, 0, 0));
        writeReg(2'd1, 32'h8);
        readReg("udf_cleared", 2'd1, 32'h0000_0001);
        pushPop("empty_pushpop", 32'hC3);
        readReg("empty_pushpop_status", 2'd1, statusWord(0, 0, 0, 1, 0, 1));
        popData("pop_c3");
        writeReg(2'd1, 32'hC);
        readReg("both_cleared", 2'd1, 32'h0000_0001);

        pushSample(32'h11);
        pushSample(32'h22);
        pushSample(32'h33);
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 2'd2, 32'h2);
        model.delete();
        readReg("flush_status", 2'd1, 32'h0000_0001);
        readReg("control_flush_reads0", 2'd2, 32'd0);

`ifdef PIO_FIFO_BUF_IRQ_EN
        writeReg(2'd3, 32'd0);
        readReg("thresh_zero_as_one", 2'd3, 32'd1);
        writeReg(2'd3, 32'd4);
        readReg("thresh_4", 2'd3, 32'd4);
        writeReg(2'd2, 32'd1);
        readReg("irq_en_set", 2'd2, 32'd1);
        for (int i = 0; i < 4; i++) pushSample(32'h50 + i);
        checkOutput("irq_not_yet", {31'd0, irq}, 32'd0);
        idleCycle();
        checkOutput("irq_asserted", {31'd0, irq}, 32'd1);
        popData("irq_pop");
        idleCycle();
        checkOutput("irq_deasserted", {31'd0, irq}, 32'd0);
`else
        writeReg(2'd3, 32'd4);
        readReg("thresh_reads0", 2'd3, 32'd0);
        writeReg(2'd2, 32'd1);
        readReg("irq_en_reads0", 2'd2, 32'd0);
        for (int i = 0; i < 4; i++) pushSample(32'h50 + i);
        idleCycle();
        checkOutput("irq_tied0", {31'd0, irq}, 32'd0);
        popData("noirq_pop");
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
